// File: rtl/ep2_packet_demux_pkg.sv
// Shared EP2 definitions: parser states, header layout and the byte-count width
// that the arbitrator also uses for its write/read FIFO byte counts.
package ep2_pkg;

  localparam int EP2_PORT_BITS = 3;
  localparam int EP2_LEN_BITS  = 16;
  localparam int BYTE_COUNT_W  = 32;

  localparam int HDR_PORT_IDX   = 0;
  localparam int HDR_LEN_HI_IDX = 1;
  localparam int HDR_LEN_LO_IDX = 2;
  localparam int HDR_BYTES      = 3;

  typedef enum logic [2:0] {
    S_PORT,
    S_LEN_HI,
    S_LEN_LO,
    S_PAYLOAD,
    S_DISCARD,
    S_CHECK
  } state_e;

endpackage

// File: rtl/ep2_packet_demux_port_counter.sv
// ep2_port_counter: per-port payload byte counter, wraps at 2^32.
module ep2_port_counter
  import ep2_pkg::*;
(
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    inc_i,
  output logic [BYTE_COUNT_W-1:0] count_o
);

  logic [BYTE_COUNT_W-1:0] count_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else if (inc_i) begin
      count_q <= count_q + BYTE_COUNT_W'(1);
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/ep2_packet_demux.sv
// ep2_packet_demux: parses the EP2 host stream and steers payload bytes to per-port write FIFOs.
// Define EP2_PACKET_CHECKSUM_EN to expect a trailing XOR checksum byte on every packet.
module ep2_packet_demux
  import ep2_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int PORT_BITS = EP2_PORT_BITS,
  parameter int LEN_BITS  = EP2_LEN_BITS
) (
  input  logic                              clk_i,
  input  logic                              reset_i,
  input  logic [7:0]                        in_data_i,
  input  logic                              in_valid_i,
  output logic                              in_ready_o,
  output logic [7:0]                        fifo_data_o,
  output logic [NUM_PORTS-1:0]              fifo_write_o,
  input  logic [NUM_PORTS-1:0]              fifo_full_i,
  output logic [BYTE_COUNT_W*NUM_PORTS-1:0] byte_count_o,
  output logic                              packet_error_o,
  output logic [15:0]                       error_count_o,
  output logic                              busy_o
);

`ifdef EP2_PACKET_CHECKSUM_EN
  localparam state_e BODY_DONE = S_CHECK;
`else
  localparam state_e BODY_DONE = S_PORT;
`endif

  state_e               state_q, state_d;
  logic [PORT_BITS-1:0] target_q, target_d;
  logic                 portOk_q, portOk_d;
  logic [7:0]           lenHi_q, lenHi_d;
  logic [LEN_BITS-1:0]  remaining_q, remaining_d;
  logic [15:0]          errorCount_q;
  logic                 packetError_q;
`ifdef EP2_PACKET_CHECKSUM_EN
  logic [7:0]           checksum_q, checksum_d;
`endif

  logic                 accept;
  logic                 errorEvent;
  logic                 targetFull;
  logic                 portInRange;
  logic [NUM_PORTS-1:0] targetOneHot;
  logic [NUM_PORTS-1:0] fifoWrite;
  logic [LEN_BITS-1:0]  lenFull;

  assign lenFull     = LEN_BITS'({lenHi_q, in_data_i});
  assign portInRange = (32'(in_data_i[PORT_BITS-1:0]) < 32'(NUM_PORTS));

  always_comb begin
    targetOneHot = '0;
    targetFull   = 1'b0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (target_q == PORT_BITS'(p)) begin
        targetOneHot[p] = 1'b1;
        targetFull      = fifo_full_i[p];
      end
    end
  end

  // Backpressure only applies while writing payload, so a write never hits a full FIFO.
  assign in_ready_o   = (state_q == S_PAYLOAD) ? !targetFull : 1'b1;
  assign accept       = in_valid_i && in_ready_o;
  assign fifoWrite    = targetOneHot & {NUM_PORTS{accept && (state_q == S_PAYLOAD)}};
  assign fifo_write_o = fifoWrite;
  assign fifo_data_o  = in_data_i;
  assign busy_o       = (state_q != S_PORT);

  always_comb begin
    state_d     = state_q;
    target_d    = target_q;
    portOk_d    = portOk_q;
    lenHi_d     = lenHi_q;
    remaining_d = remaining_q;
    errorEvent  = 1'b0;
`ifdef EP2_PACKET_CHECKSUM_EN
    checksum_d  = checksum_q;
`endif
    if (accept) begin
      unique case (state_q)
        S_PORT: begin
          target_d = in_data_i[PORT_BITS-1:0];
          portOk_d = portInRange;
          state_d  = S_LEN_HI;
        end
        S_LEN_HI: begin
          lenHi_d = in_data_i;
          state_d = S_LEN_LO;
        end
        S_LEN_LO: begin
          remaining_d = lenFull;
`ifdef EP2_PACKET_CHECKSUM_EN
          checksum_d  = '0;
`endif
          if (lenFull == '0) begin
            state_d = BODY_DONE;
          end else if (portOk_q) begin
            state_d = S_PAYLOAD;
          end else begin
            state_d    = S_DISCARD;
            errorEvent = 1'b1;
          end
        end
        S_PAYLOAD: begin
          remaining_d = remaining_q - LEN_BITS'(1);
`ifdef EP2_PACKET_CHECKSUM_EN
          checksum_d  = checksum_q ^ in_data_i;
`endif
          if (remaining_q == LEN_BITS'(1)) state_d = BODY_DONE;
        end
        S_DISCARD: begin
          remaining_d = remaining_q - LEN_BITS'(1);
          if (remaining_q == LEN_BITS'(1)) state_d = BODY_DONE;
        end
`ifdef EP2_PACKET_CHECKSUM_EN
        // Discarded packets were already flagged at the length byte.
        S_CHECK: begin
          if (portOk_q && (in_data_i != checksum_q)) errorEvent = 1'b1;
          state_d = S_PORT;
        end
`endif
        default: state_d = S_PORT;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= S_PORT;
      target_q    <= '0;
      portOk_q    <= 1'b0;
      lenHi_q     <= '0;
      remaining_q <= '0;
`ifdef EP2_PACKET_CHECKSUM_EN
      checksum_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      target_q    <= target_d;
      portOk_q    <= portOk_d;
      lenHi_q     <= lenHi_d;
      remaining_q <= remaining_d;
`ifdef EP2_PACKET_CHECKSUM_EN
      checksum_q  <= checksum_d;
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      packetError_q <= 1'b0;
      errorCount_q  <= '0;
    end else begin
      packetError_q <= errorEvent;
      if (errorEvent && (errorCount_q != 16'hFFFF)) errorCount_q <= errorCount_q + 16'd1;
    end
  end

  assign packet_error_o = packetError_q;
  assign error_count_o  = errorCount_q;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    ep2_port_counter u_counter (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .inc_i   (fifoWrite[p]),
      .count_o (byte_count_o[BYTE_COUNT_W*p +: BYTE_COUNT_W])
    );
  end

endmodule

// File: tb/tb_ep2_packet_demux.sv
// Self-checking bench for ep2_packet_demux: directed packets plus randomized traffic vs a packet-level model.
// Checksum trailers are generated and checked when EP2_PACKET_CHECKSUM_EN is defined.
module tb_ep2_packet_demux;

  typedef logic [7:0] byteQ_t[$];
  localparam int NUM_PORTS = 4;

  logic                   clk = 1'b0;
  logic                   reset = 1'b1;
  logic [7:0]             inData = '0;
  logic                   inValid = 1'b0;
  logic                   inReady;
  logic [7:0]             fifoData;
  logic [NUM_PORTS-1:0]   fifoWrite;
  logic [NUM_PORTS-1:0]   fifoFull = '0;
  logic [32*NUM_PORTS-1:0] byteCount;
  logic                   packetError;
  logic [15:0]            errorCount;
  logic                   busy;

  int          testsRun = 0;
  int          failCount = 0;
  logic [15:0] obsQ[$];
  logic [15:0] expQ[$];
  logic [31:0] modelCnt[NUM_PORTS];
  int          modelErr = 0;
  int          errPulses = 0;
  int          errBase = 0;
  int          fullViolations = 0;
  bit          rndGap = 1'b0;
  bit          rndFull = 1'b0;

  ep2_packet_demux #(.NUM_PORTS(NUM_PORTS)) dut (
    .clk_i          (clk),
    .reset_i        (reset),
    .in_data_i      (inData),
    .in_valid_i     (inValid),
    .in_ready_o     (inReady),
    .fifo_data_o    (fifoData),
    .fifo_write_o   (fifoWrite),
    .fifo_full_i    (fifoFull),
    .byte_count_o   (byteCount),
    .packet_error_o (packetError),
    .error_count_o  (errorCount),
    .busy_o         (busy)
  );

  always #5 clk = ~clk;

  // Records every FIFO write and error pulse, sampled on the falling edge.
  always @(negedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (fifoWrite[i]) begin
          obsQ.push_back({8'(i), fifoData});
          if (fifoFull[i]) fullViolations++;
        end
      end
      if (packetError) errPulses++;
    end
  end

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  function automatic byteQ_t makePacket(input logic [7:0] hdr, input logic [15:0] len, input byteQ_t payload);
    byteQ_t q;
    q = {hdr, len[15:8], len[7:0]};
    foreach (payload[k]) q.push_back(payload[k]);
`ifdef EP2_PACKET_CHECKSUM_EN
    begin
      logic [7:0] x;
      x = '0;
      foreach (payload[k]) x ^= payload[k];
      q.push_back(x);
    end
`endif
    return q;
  endfunction

  // Packet-level reference: which bytes land where, byte counts and bad packets.
  task automatic modelPacket(input byteQ_t pkt);
    int port;
    int len;
    port = int'(pkt[0][2:0]);
    len  = int'({pkt[1], pkt[2]});
    for (int k = 0; k < len; k++) begin
      if (port < NUM_PORTS) expQ.push_back({8'(port), pkt[3+k]});
    end
    if (port < NUM_PORTS) modelCnt[port] += 32'(len);
    else if (len != 0 && modelErr < 65535) modelErr++;
`ifdef EP2_PACKET_CHECKSUM_EN
    begin
      logic [7:0] x;
      x = '0;
      for (int k = 0; k < len; k++) x ^= pkt[3+k];
      if (port < NUM_PORTS && pkt[3+len] != x && modelErr < 65535) modelErr++;
    end
`endif
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input byteQ_t pkt);
    foreach (pkt[k]) begin
      int   gap;
      int   waitCycles;
      logic accepted;
      gap = rndGap ? $urandom_range(0, 2) : 0;
      repeat (gap) begin
        inValid = 1'b0;
        if (rndFull) fifoFull = NUM_PORTS'($urandom & $urandom);
        @(posedge clk);
        #1;
      end
      inData     = pkt[k];
      inValid    = 1'b1;
      accepted   = 1'b0;
      waitCycles = 0;
      while (!accepted && waitCycles <= 200) begin
        @(negedge clk);
        accepted = inReady;
        @(posedge clk);
        #1;
        if (rndFull) fifoFull = NUM_PORTS'($urandom & $urandom);
        if (!accepted) waitCycles++;
      end
      if (!accepted) checkOutput("accept_timeout", 32'(accepted), 32'd1);
    end
    inValid = 1'b0;
  endtask

  task automatic compareWrites(input string tag);
    checkOutput({tag, "_nwrites"}, 32'(obsQ.size()), 32'(expQ.size()));
    for (int k = 0; k < obsQ.size() && k < expQ.size(); k++)
      checkOutput($sformatf("%s_write%0d", tag, k), 32'(obsQ[k]), 32'(expQ[k]));
    obsQ.delete();
    expQ.delete();
  endtask

  task automatic checkCounts(input string tag);
    for (int i = 0; i < NUM_PORTS; i++)
      checkOutput($sformatf("%s_bytecount%0d", tag, i), byteCount[32*i +: 32], modelCnt[i]);
    checkOutput({tag, "_errcount"}, 32'(errorCount), 32'(modelErr));
    checkOutput({tag, "_errpulses"}, 32'(errPulses - errBase), 32'(modelErr));
  endtask

  task automatic doReset();
    reset    = 1'b1;
    inValid  = 1'b0;
    fifoFull = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    obsQ.delete();
    expQ.delete();
    foreach (modelCnt[i]) modelCnt[i] = '0;
    modelErr = 0;
    errBase  = errPulses;
  endtask

  initial begin
    byteQ_t     pl;
    byteQ_t     pkt;
    byteQ_t     pkt2;
    byteQ_t     emptyQ;
    int         len;
    int         stalls;
    logic [7:0] hdr;

    emptyQ = {};
    doReset();
    checkOutput("reset_in_ready", 32'(inReady), 32'd1);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_fifo_write", 32'(fifoWrite), 32'd0);
    checkOutput("reset_packet_error", 32'(packetError), 32'd0);
    checkCounts("reset");

    pl  = {8'hAA, 8'hBB, 8'hCC};
    pkt = makePacket(8'h02, 16'd3, pl);
    modelPacket(pkt);
    applyStimulus(pkt);
    idle(3);
    compareWrites("basic");
    checkCounts("basic");

    pl  = {8'h10, 8'h20, 8'h30, 8'h40};
    pkt = makePacket(8'h01, 16'd4, pl);
    modelPacket(pkt);
    applyStimulus(pkt[0:4]);
    fifoFull = 4'b0010;
    inData   = pkt[5];
    inValid  = 1'b1;
    stalls   = 0;
    repeat (5) begin
      @(negedge clk);
      if (!inReady) stalls++;
      @(posedge clk);
      #1;
    end
    fifoFull = '0;
    inValid  = 1'b0;
    checkOutput("stall_cycles", 32'(stalls), 32'd5);
    applyStimulus(pkt[5:$]);
    idle(3);
    compareWrites("stall");
    checkCounts("stall");

    pl  = {8'h12, 8'h34};
    pkt = makePacket(8'h06, 16'd2, pl);
    modelPacket(pkt);
    applyStimulus(pkt);
    idle(3);
    compareWrites("badport");
    checkCounts("badport");

    pkt  = makePacket(8'h00, 16'd0, emptyQ);
    pl   = {8'h5A};
    pkt2 = makePacket(8'h03, 16'd1, pl);
    modelPacket(pkt);
    modelPacket(pkt2);
    applyStimulus({pkt, pkt2});
    checkOutput("b2b_busy_after", 32'(busy), 32'd0);
    idle(3);
    compareWrites("b2b");
    checkCounts("b2b");

    pl  = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    pkt = makePacket(8'h00, 16'd5, pl);
    applyStimulus(pkt[0:4]);
    idle(1);
    checkOutput("midreset_partial_writes", 32'(obsQ.size()), 32'd2);
    doReset();
    checkOutput("midreset_in_ready", 32'(inReady), 32'd1);
    checkOutput("midreset_busy", 32'(busy), 32'd0);
    checkCounts("midreset");
    pl  = {8'h11};
    pkt = makePacket(8'h00, 16'd1, pl);
    modelPacket(pkt);
    applyStimulus(pkt);
    idle(3);
    compareWrites("postreset");
    checkCounts("postreset");

`ifdef EP2_PACKET_CHECKSUM_EN
    pl  = {8'h0F, 8'hF0};
    pkt = makePacket(8'h01, 16'd2, pl);
    modelPacket(pkt);
    applyStimulus(pkt);
    idle(3);
    compareWrites("csum_good");
    checkCounts("csum_good");
    pkt[pkt.size()-1] = 8'h00;
    modelPacket(pkt);
    applyStimulus(pkt);
    idle(3);
    compareWrites("csum_bad");
    checkCounts("csum_bad");
`endif

    rndGap  = 1'b1;
    rndFull = 1'b1;
    for (int n = 0; n < 30; n++) begin
      len = $urandom_range(0, 10);
      pl  = {};
      for (int k = 0; k < len; k++) pl.push_back(8'($urandom));
      hdr = 8'($urandom);
      pkt = makePacket(hdr, 16'(len), pl);
`ifdef EP2_PACKET_CHECKSUM_EN
      if ($urandom_range(0, 3) == 0) pkt[pkt.size()-1] = pkt[pkt.size()-1] ^ 8'h5A;
`endif
      modelPacket(pkt);
      applyStimulus(pkt);
      idle(3);
      compareWrites($sformatf("rand%0d", n));
    end
    rndGap   = 1'b0;
    rndFull  = 1'b0;
    fifoFull = '0;
    idle(2);
    checkCounts("rand");
    checkOutput("write_into_full", 32'(fullViolations), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
